reg_write_buffer: RTL and testbench
===================================

REG_WRITE_BUFFER -- requirements
Module: reg_write_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued writes (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  producer (writeback stage) presents a register write.
REQ-005 in_ready  output  1  buffer can accept a write this cycle.
REQ-006 in_dr  input  3  destination register R0-R7 of offered write.
REQ-007 in_data  input  16  value of offered write.
REQ-008 hold  input  1  when 1, no entry is drained to the register file this cycle.
REQ-009 rf_we  output  1  write enable to register file.
REQ-010 rf_dr  output  3  destination register to register file.
REQ-011 rf_data  output  16  write data to register file.
REQ-012 sr1, sr2  input  3 each  source registers being read by decode this cycle.
REQ-013 sr1_hit, sr2_hit  output  1 each  a pending write to that source exists in the buffer.
REQ-014 sr1_fwd, sr2_fwd  output  16 each  youngest pending value for that source; 0 when no hit.
REQ-015 empty  output  1  no pending writes.

Function
REQ-016 The buffer SHALL be a FIFO of DEPTH entries {dr, data} with head/tail pointers wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH), combinationally from registered count only; it SHALL NOT depend on hold or same-cycle drain.
REQ-018 A write SHALL be enqueued at posedge clk when in_valid && in_ready; when in_valid && !in_ready the offer SHALL be ignored and the producer keeps it stable.
REQ-019 rf_we SHALL be 1 exactly when !empty && !hold; rf_dr/rf_data SHALL be the head entry when !empty, else 0.
REQ-020 The head SHALL be popped at the posedge where rf_we=1 (register file samples the same edge); drain rate one entry per cycle.
REQ-021 Latency: an entry enqueued at edge N SHALL appear on rf_* no earlier than the cycle after edge N (no combinational pass-through from in_* to rf_*).
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers; at count=DEPTH enqueue is blocked even if a drain occurs.
REQ-023 Writes to the same dr SHALL drain in enqueue order; no merging or dropping.
REQ-024 srX_hit SHALL be 1 when any occupied entry, including the head being drained this cycle, has dr==srX; srX_fwd SHALL be the data of the youngest such entry.
REQ-025 The write offered on in_* in the current cycle SHALL NOT be forwarded.
REQ-026 hold held high with count=DEPTH SHALL keep in_ready=0 and all contents unchanged indefinitely.
REQ-027 empty SHALL equal (count==0).

Reset
REQ-028 rst_n low SHALL asynchronously clear count, head and tail to 0 and all entry fields to 0, discarding pending writes, including mid-drain.
REQ-029 During and immediately after reset: rf_we=0, rf_dr=0, rf_data=0, in_ready=1, empty=1, srX_hit=0, srX_fwd=0.

Structure
REQ-030 Shared package lc3b_pkg SHALL hold REG_ADDR_W=3, DATA_W=16 and the default write-buffer depth constant.
REQ-031 Forwarding SHALL be implemented in one sub-module reg_fwd_select (inputs: entry array, valid mask, age order, source reg; outputs: hit, data), instantiated twice.
REQ-032 No other sub-modules; FIFO storage and pointers live in reg_write_buffer.

Verification
REQ-033 Reset, then enqueue {R3,0x1234} with hold=0 -> next cycle rf_we=1, rf_dr=3, rf_data=0x1234; following cycle empty=1, rf_we=0.
REQ-034 hold=1, enqueue 4 writes R0..R3 (0xA000..0xA003) -> in_ready=0 after 4th; 5th offer ignored; release hold -> four rf_we pulses in order R0..R3, then in_ready=1.
REQ-035 hold=1, enqueue {R5,0x0011} then {R5,0x0022}; sr1=5 -> sr1_hit=1, sr1_fwd=0x0022; sr2=6 -> sr2_hit=0, sr2_fwd=0.
REQ-036 Full buffer, hold=0, in_valid=1 -> no enqueue on that edge; next cycle count=3 and enqueue accepted while draining; count stays 3.
REQ-037 Assert rst_n=0 mid-cycle with 3 pending entries and rf_we=1 -> rf_we drops immediately, no further register file writes after release, empty=1.
REQ-038 Offer {R2,0xBEEF} with sr1=2 on empty buffer -> sr1_hit=0 that cycle, sr1_hit=1 with 0xBEEF next cycle if hold=1.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared LC-3b datapath constants and the register write-buffer entry type.
package lc3b_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 16;
   localparam int WB_DEPTH   = 4;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/reg_fwd_select.sv
// Picks the youngest pending write to one source register out of the
// write-buffer ring; age is measured from the head (oldest) slot.
module reg_fwd_select
   import lc3b_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  wb_entry_t [DEPTH-1:0]   entries_i,
   input  logic [DEPTH-1:0]        valid_i,
   input  logic [PTR_W-1:0]        head_i,
   input  logic [REG_ADDR_W-1:0]   src_i,
   output logic                    hit_o,
   output logic [DATA_W-1:0]       data_o
);

   logic [PTR_W-1:0] idx_s;
   logic             match_s;

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      hit_o   = 1'b0;
      data_o  = '0;
      idx_s   = '0;
      match_s = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         idx_s   = head_i + PTR_W'(k);
         match_s = valid_i[idx_s] && (entries_i[idx_s].dr == src_i);
         hit_o   = hit_o | match_s;
         data_o  = match_s ? entries_i[idx_s].data : data_o;
      end
   end

endmodule

// File: rtl/reg_write_buffer.sv
// Writeback-to-register-file FIFO with per-source forwarding of pending writes.
// Drains one entry per cycle unless hold is asserted.
module reg_write_buffer
   import lc3b_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_dr,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  hold,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_dr,
   output logic [DATA_W-1:0]     rf_data,
   input  logic [REG_ADDR_W-1:0] sr1,
   input  logic [REG_ADDR_W-1:0] sr2,
   output logic                  sr1_hit,
   output logic                  sr2_hit,
   output logic [DATA_W-1:0]     sr1_fwd,
   output logic [DATA_W-1:0]     sr2_fwd,
   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DEPTH-1:0]      valid_s;
   logic [PTR_W-1:0]      age_s;
   logic                  push_s;
   logic                  pop_s;

   // Readiness and emptiness come from the registered count only.
   assign in_ready = (count_q < CNT_W'(DEPTH));
   assign empty    = (count_q == CNT_W'(0));
   assign push_s   = in_valid && in_ready;
   assign pop_s    = rf_we;

   // Register-file port presents the head entry; zeros when nothing is pending.
   always_comb begin
      rf_we   = 1'b0;
      rf_dr   = '0;
      rf_data = '0;
      if (!empty) begin
         rf_we   = !hold;
         rf_dr   = mem_q[head_q].dr;
         rf_data = mem_q[head_q].data;
      end else begin
         rf_we   = 1'b0;
         rf_dr   = '0;
         rf_data = '0;
      end
   end

   // A slot is occupied when its distance from the head is below the count.
   always_comb begin
      valid_s = '0;
      age_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_s      = PTR_W'(i) - head_q;
         valid_s[i] = ({1'b0, age_s} < count_q);
      end
   end

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d  = mem_q;
      head_d = pop_s  ? head_q + PTR_W'(1) : head_q;
      tail_d = push_s ? tail_q + PTR_W'(1) : tail_q;
      if (push_s) begin
         mem_d[tail_q] = '{dr: in_dr, data: in_data};
      end else begin
         mem_d = mem_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards every pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   reg_fwd_select #(.DEPTH(DEPTH)) u_fwd_sr1 (
      .entries_i (mem_q),
      .valid_i   (valid_s),
      .head_i    (head_q),
      .src_i     (sr1),
      .hit_o     (sr1_hit),
      .data_o    (sr1_fwd)
   );

   reg_fwd_select #(.DEPTH(DEPTH)) u_fwd_sr2 (
      .entries_i (mem_q),
      .valid_i   (valid_s),
      .head_i    (head_q),
      .src_i     (sr2),
      .hit_o     (sr2_hit),
      .data_o    (sr2_fwd)
   );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench: scoreboard of accepted writes checked against rf_* drains,
// plus directed checks of readiness, forwarding and reset behaviour.
module tb_reg_write_buffer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_dr;
   logic [15:0] in_data;
   logic        hold;
   logic        rf_we;
   logic [2:0]  rf_dr;
   logic [15:0] rf_data;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic        sr1_hit;
   logic        sr2_hit;
   logic [15:0] sr1_fwd;
   logic [15:0] sr2_fwd;
   logic        empty;

   int          n_cmp;
   int          n_mis;
   logic [18:0] sb_q[$];
   logic [18:0] sb_e;

   reg_write_buffer #(.DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_dr    (in_dr),
      .in_data  (in_data),
      .hold     (hold),
      .rf_we    (rf_we),
      .rf_dr    (rf_dr),
      .rf_data  (rf_data),
      .sr1      (sr1),
      .sr2      (sr2),
      .sr1_hit  (sr1_hit),
      .sr2_hit  (sr2_hit),
      .sr1_fwd  (sr1_fwd),
      .sr2_fwd  (sr2_fwd),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [2:0] dr, input logic [15:0] d, input logic h);
      in_valid = v;
      in_dr    = dr;
      in_data  = d;
      hold     = h;
   endtask

   // Drains must match accepted writes in order; acceptance is sampled before the edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rf_we) begin
            if (sb_q.size() == 0) begin
               check_val("rf_we_spurious", 32'd1, 32'd0);
            end else begin
               sb_e = sb_q.pop_front();
               check_val("rf_dr_order", {29'd0, rf_dr}, {29'd0, sb_e[18:16]});
               check_val("rf_data_order", {16'd0, rf_data}, {16'd0, sb_e[15:0]});
            end
         end
         if (in_valid && in_ready) sb_q.push_back({in_dr, in_data});
      end
   end

   always @(negedge rst_n) sb_q.delete();

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_mis = 0;
      rst_n = 1'b0;
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      sr1 = 3'd3;
      sr2 = 3'd0;

      // Reset state
      @(negedge clk);
      check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check_val("rst_rf_dr", {29'd0, rf_dr}, 32'd0);
      check_val("rst_rf_data", {16'd0, rf_data}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_empty", {31'd0, empty}, 32'd1);
      check_val("rst_sr1_hit", {31'd0, sr1_hit}, 32'd0);
      check_val("rst_sr2_fwd", {16'd0, sr2_fwd}, 32'd0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_empty", {31'd0, empty}, 32'd1);
      next_cycle();

      // Single write, one-cycle latency then drain
      offer(1'b1, 3'd3, 16'h1234, 1'b0);
      @(negedge clk);
      check_val("lat_no_passthru", {31'd0, rf_we}, 32'd0);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      @(negedge clk);
      check_val("single_rf_we", {31'd0, rf_we}, 32'd1);
      check_val("single_rf_dr", {29'd0, rf_dr}, 32'd3);
      check_val("single_rf_data", {16'd0, rf_data}, 32'h1234);
      next_cycle();
      @(negedge clk);
      check_val("single_empty", {31'd0, empty}, 32'd1);
      check_val("single_rf_we_off", {31'd0, rf_we}, 32'd0);
      next_cycle();

      // Fill under hold, fifth offer refused, hold keeps full buffer frozen
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b1);
         @(negedge clk);
         check_val("fill_ready", {31'd0, in_ready}, 32'd1);
         next_cycle();
      end
      offer(1'b1, 3'd4, 16'hA004, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("full_ready", {31'd0, in_ready}, 32'd0);
         check_val("full_hold_we", {31'd0, rf_we}, 32'd0);
         next_cycle();
      end
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("drain_we", {31'd0, rf_we}, 32'd1);
         next_cycle();
      end
      @(negedge clk);
      check_val("drained_ready", {31'd0, in_ready}, 32'd1);
      check_val("drained_empty", {31'd0, empty}, 32'd1);
      next_cycle();

      // Youngest-wins forwarding
      offer(1'b1, 3'd5, 16'h0011, 1'b1);
      next_cycle();
      offer(1'b1, 3'd5, 16'h0022, 1'b1);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b1);
      sr1 = 3'd5;
      sr2 = 3'd6;
      @(negedge clk);
      check_val("fwd_sr1_hit", {31'd0, sr1_hit}, 32'd1);
      check_val("fwd_sr1_data", {16'd0, sr1_fwd}, 32'h0022);
      check_val("fwd_sr2_hit", {31'd0, sr2_hit}, 32'd0);
      check_val("fwd_sr2_data", {16'd0, sr2_fwd}, 32'h0000);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      check_val("fwd_drained", {31'd0, empty}, 32'd1);
      next_cycle();

      // Full with drain: blocked on that edge, then enqueue-while-drain holds count
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 3'(i), 16'hB000 + 16'(i), 1'b1);
         next_cycle();
      end
      offer(1'b1, 3'd7, 16'h7777, 1'b0);
      @(negedge clk);
      check_val("fulldrain_blocked", {31'd0, in_ready}, 32'd0);
      check_val("fulldrain_we", {31'd0, rf_we}, 32'd1);
      next_cycle();
      @(negedge clk);
      check_val("fulldrain_ready3", {31'd0, in_ready}, 32'd1);
      next_cycle();
      offer(1'b1, 3'd6, 16'h6666, 1'b1);
      @(negedge clk);
      check_val("count3_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b1);
      @(negedge clk);
      check_val("count_stays3", {31'd0, in_ready}, 32'd0);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++) next_cycle();
      @(negedge clk);
      check_val("fulldrain_empty", {31'd0, empty}, 32'd1);
      next_cycle();

      // Offered write is not forwarded; pending and head-being-drained are
      sr1 = 3'd2;
      offer(1'b1, 3'd2, 16'hBEEF, 1'b1);
      @(negedge clk);
      check_val("offer_no_fwd_hit", {31'd0, sr1_hit}, 32'd0);
      check_val("offer_no_fwd_data", {16'd0, sr1_fwd}, 32'h0000);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b1);
      @(negedge clk);
      check_val("pend_fwd_hit", {31'd0, sr1_hit}, 32'd1);
      check_val("pend_fwd_data", {16'd0, sr1_fwd}, 32'hBEEF);
      next_cycle();
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      @(negedge clk);
      check_val("head_drain_hit", {31'd0, sr1_hit}, 32'd1);
      next_cycle();
      @(negedge clk);
      check_val("after_drain_hit", {31'd0, sr1_hit}, 32'd0);
      next_cycle();

      // Asynchronous reset mid-drain
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 3'(i + 1), 16'hC000 + 16'(i), 1'b1);
         next_cycle();
      end
      offer(1'b0, 3'd0, 16'h0000, 1'b0);
      #2;
      check_val("mid_rst_pre_we", {31'd0, rf_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_we", {31'd0, rf_we}, 32'd0);
      check_val("mid_rst_data", {16'd0, rf_data}, 32'd0);
      check_val("mid_rst_empty", {31'd0, empty}, 32'd1);
      check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("post_rst_no_we", {31'd0, rf_we}, 32'd0);
         check_val("post_rst_empty2", {31'd0, empty}, 32'd1);
         next_cycle();
      end

      check_val("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
